seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 The module SHALL have parameter W, default 8: the maximum pattern length in bits (2..16).
REQ-002 The module SHALL have parameter LW, default 4: the width of len, equal to ceil(log2(W+1)).
REQ-003 The module SHALL have parameter CW, default 4: the width of reps and gap.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: a request to begin a transmission, sampled on clk.
REQ-007 The module SHALL have port abort, input, 1 bit: a request to cancel the current transmission.
REQ-008 The module SHALL have port pattern, input, W bits: the bit pattern to send, right-aligned.
REQ-009 The module SHALL have port len, input, LW bits: the number of pattern bits to send, valid range 1..W.
REQ-010 The module SHALL have port reps, input, CW bits: the repetition count; the pattern is sent reps+1 times.
REQ-011 The module SHALL have port gap, input, CW bits: the number of idle cycles between repetitions.
REQ-012 The module SHALL have port bit_ready, input, 1 bit: the consumer accepts bit_out.
REQ-013 The module SHALL have port bit_valid, output, 1 bit: bit_out holds a valid serial bit.
REQ-014 The module SHALL have port bit_out, output, 1 bit: the serial data bit.
REQ-015 The module SHALL have port busy, output, 1 bit: a transmission is in progress.
REQ-016 The module SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND, GAP and DONE, and all outputs SHALL be registered (Moore).
REQ-018 In IDLE, start=1 with len in 1..W SHALL capture pattern, len, reps and gap into internal registers and enter SEND on the next edge.
REQ-019 In IDLE, start=1 with len=0 or len>W SHALL be ignored: the FSM stays in IDLE and done is not pulsed.
REQ-020 start SHALL be ignored while busy=1, and later changes to pattern, len, reps or gap SHALL NOT affect an accepted job.
REQ-021 Latency: when start is accepted at edge k, bit_valid SHALL be 1 in the cycle after edge k, carrying the first bit.
REQ-022 Bits SHALL be sent MSB-first over the low len bits: the first bit is pattern[len-1] and the last bit is pattern[0].
REQ-023 In SEND, bit_valid SHALL be 1, and the bit index SHALL advance only on an edge where bit_valid=1 and bit_ready=1.
REQ-024 While bit_valid=1 and bit_ready=0, bit_out SHALL hold its value (no drop, no skip).
REQ-025 On acceptance of the last bit of a repetition, with repetitions remaining and gap>0, the FSM SHALL enter GAP.
REQ-026 In GAP, bit_valid SHALL be 0 and bit_out SHALL be 0 for exactly gap cycles, after which the FSM SHALL return to SEND at bit len-1.
REQ-027 On acceptance of the last bit of a repetition, with repetitions remaining and gap=0, the FSM SHALL stay in SEND with the first bit on the next cycle (back-to-back, no bubble).
REQ-028 On acceptance of the last bit of the final repetition, the FSM SHALL enter DONE.
REQ-029 DONE SHALL last one cycle with done=1 and bit_valid=0, and the FSM SHALL then enter IDLE.
REQ-030 busy SHALL be 1 in SEND, GAP and DONE, and 0 in IDLE.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge, with bit_valid=0, busy=0 and no done pulse.
REQ-032 abort SHALL take priority over start in the same cycle, so no job is accepted.
REQ-033 A start arriving in the DONE cycle SHALL be ignored, so a new start is accepted no earlier than the first IDLE cycle.
REQ-034 The repetition counter SHALL count down from reps to 0 without wrap-around; reps=2^CW-1 SHALL give 2^CW repetitions.
REQ-035 The bit-index counter SHALL run from len-1 down to 0 and SHALL NOT underflow.
REQ-036 When len=1, each repetition SHALL be a single bit.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE and clear all internal registers.
REQ-038 During reset, bit_valid, bit_out, busy and done SHALL all be 0.
REQ-039 Reset asserted mid-SEND or mid-GAP SHALL discard the job; after release, the block SHALL be in IDLE waiting for start.

Verification
REQ-040 The bench SHALL check: pattern=8'b0000_1011, len=4, reps=0, gap=0, bit_ready=1 -> bit_out 1,0,1,1 on 4 consecutive cycles, then done=1 for one cycle, then busy=0.
REQ-041 The bench SHALL check: pattern=3'b110, len=3, reps=2, gap=2 -> 110, 00 (bit_valid=0), 110, 00, 110, done, for 14 busy cycles in total.
REQ-042 The bench SHALL check: bit_ready toggling 1,0,0,1,... on pattern 4'b1001 -> each bit held while not ready, the sequence 1,0,0,1 is intact, and done arrives after the 4th handshake.
REQ-043 The bench SHALL check: abort asserted on the 3rd bit of an 8-bit job -> next cycle busy=0 and bit_valid=0, no done, and a fresh start is accepted immediately afterwards.
REQ-044 The bench SHALL check: start with len=0, and start while busy -> both ignored, with no state change and no done.
REQ-045 The bench SHALL check: rst_n pulsed low mid-GAP -> outputs go to 0 asynchronously, then IDLE after release.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
//
// Serialises the low `len` bits of a captured pattern, MSB first, over a
// valid/ready bit stream. The pattern is repeated reps+1 times, with `gap`
// idle cycles between repetitions. A one-cycle `done` pulse marks normal
// completion; `abort` cancels a job silently.
//
// Parameters
//   W   maximum pattern length in bits (2..16)
//   LW  width of len, ceil(log2(W+1))
//   CW  width of reps and gap
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new transmission (accepted in IDLE only)
//   abort      cancel the current transmission, return to IDLE
//   pattern    bit pattern, right-aligned
//   len        number of pattern bits to send, 1..W
//   reps       repetition count, pattern sent reps+1 times
//   gap        idle cycles between repetitions
//   bit_ready  consumer accepts bit_out
//   bit_valid  bit_out holds a valid serial bit
//   bit_out    serial data bit
//   busy       transmission in progress (SEND, GAP, DONE)
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_pattern_gen #(
    parameter int W  = 8,
    parameter int LW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [CW-1:0] reps,
    input  logic [CW-1:0] gap,
    input  logic          bit_ready,
    output logic          bit_valid,
    output logic          bit_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LW-1:0] LEN_MAX = LW'(W);
    localparam logic [W-1:0]  ONE_W   = W'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q,   pat_d;
    logic [LW-1:0] len_q,   len_d;
    logic [LW-1:0] idx_q,   idx_d;
    logic [CW-1:0] rep_q,   rep_d;
    logic [CW-1:0] gap_q,   gap_d;
    logic [CW-1:0] gcnt_q,  gcnt_d;
    logic          valid_q, valid_d;
    logic          bit_q,   bit_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          len_ok;
    logic [LW-1:0] len_in_top;
    logic [LW-1:0] len_q_top;
    logic [LW-1:0] idx_dec;
    logic          bit_first_in;
    logic          bit_first_q;
    logic          bit_next_q;
    logic          handshake;

    assign len_ok     = (len != '0) && (len <= LEN_MAX);
    assign len_in_top = len - 1'b1;
    assign len_q_top  = len_q - 1'b1;
    // idx_dec wraps when idx_q is 0, but it is only used when idx_q != 0.
    assign idx_dec    = idx_q - 1'b1;

    // Bit selection by mask so the full pattern width participates.
    assign bit_first_in = |(pattern & (ONE_W << len_in_top));
    assign bit_first_q  = |(pat_q   & (ONE_W << len_q_top));
    assign bit_next_q   = |(pat_q   & (ONE_W << idx_dec));

    assign handshake = valid_q && bit_ready;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and next (registered) outputs. Outputs are computed for the
    // state being entered, so every output is a flop.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && len_ok) begin
                        pat_d   = pattern;
                        len_d   = len;
                        rep_d   = reps;
                        gap_d   = gap;
                        idx_d   = len_in_top;
                        state_d = SEND;
                        valid_d = 1'b1;
                        bit_d   = bit_first_in;
                        busy_d  = 1'b1;
                    end
                end

                SEND: begin
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    bit_d   = bit_q;
                    if (handshake) begin
                        if (idx_q != '0) begin
                            idx_d = idx_dec;
                            bit_d = bit_next_q;
                        end else if (rep_q != '0) begin
                            rep_d = rep_q - 1'b1;
                            idx_d = len_q_top;
                            if (gap_q != '0) begin
                                state_d = GAP;
                                gcnt_d  = gap_q;
                                valid_d = 1'b0;
                                bit_d   = 1'b0;
                            end else begin
                                bit_d = bit_first_q;
                            end
                        end else begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            bit_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end

                GAP: begin
                    busy_d = 1'b1;
                    // gcnt_q holds the idle cycles still to spend, including
                    // the current one.
                    if (gcnt_q == ONE_C) begin
                        gcnt_d  = '0;
                        state_d = SEND;
                        valid_d = 1'b1;
                        bit_d   = bit_first_q;
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bit_valid = valid_q;
    assign bit_out   = bit_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
`timescale 1ns/1ps

module tb_seq_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       bit_ready;
    logic       bit_valid;
    logic       bit_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-cycle outputs {busy, done, bit_valid, bit_out}.
    logic [3:0] exp_q[$];

    int abort_at  = -1;
    int inject_at = -1;   // -2: inject in the DONE cycle
    int reset_at  = -1;
    int job_id    = 0;

    seq_pattern_gen #(.W(8), .LW(4), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .gap       (gap),
        .bit_ready (bit_ready),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (c % 3) == 0;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({busy, done, bit_valid, bit_out});
    endfunction

    // Reference trace: MSB-first bits of each repetition (a bit repeats
    // until a cycle with ready), gap idle cycles between repetitions, one
    // DONE cycle, then idle.
    task automatic build(input logic [7:0] p, input int l, input int r, input int g, input int mode);
        int c;
        bit acc;
        exp_q.delete();
        c = 0;
        for (int rr = 0; rr <= r; rr++) begin
            for (int i = l - 1; i >= 0; i--) begin
                acc = 1'b0;
                while (!acc) begin
                    exp_q.push_back({3'b101, p[i]});
                    acc = rdy(mode, c);
                    c++;
                end
            end
            if (rr < r) begin
                for (int k = 0; k < g; k++) begin
                    exp_q.push_back(4'b1000);
                    c++;
                end
            end
        end
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0000);
    endtask

    task automatic scramble();
        pattern = 8'($urandom);
        len     = 4'($urandom);
        reps    = 4'($urandom);
        gap     = 4'($urandom);
    endtask

    task automatic run_job(input logic [7:0] p, input int l, input int r, input int g, input int mode);
        int c;
        logic [3:0] e;
        build(p, l, r, g, mode);
        pattern   = p;
        len       = 4'(l);
        reps      = 4'(r);
        gap       = 4'(g);
        start     = 1'b1;
        bit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble();
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("trace job%0d c%0d", job_id, c), outs(), 32'(e));
            abort = 1'b0;
            start = 1'b0;
            if (c == inject_at || (inject_at == -2 && e == 4'b1100)) begin
                start   = 1'b1;
                pattern = 8'hFF;
                len     = 4'd8;
                reps    = 4'd3;
                gap     = 4'd0;
            end
            bit_ready = rdy(mode, c);
            if (c == abort_at) begin
                abort = 1'b1;
                exp_q.delete();
                exp_q.push_back(4'b0000);
                exp_q.push_back(4'b0000);
            end
            if (c == reset_at) begin
                #1 rst_n = 1'b0;
                #1 check_eq($sformatf("async reset job%0d", job_id), outs(), 32'd0);
                @(negedge clk);
                check_eq($sformatf("held reset job%0d", job_id), outs(), 32'd0);
                rst_n = 1'b1;
                exp_q.delete();
                exp_q.push_back(4'b0000);
                exp_q.push_back(4'b0000);
            end
            if (exp_q.size() > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            c++;
        end
        start     = 1'b0;
        abort     = 1'b0;
        bit_ready = 1'b1;
        abort_at  = -1;
        inject_at = -1;
        reset_at  = -1;
        job_id++;
    endtask

    // A start in IDLE that must be ignored (bad len, or abort in same cycle).
    task automatic idle_start(input string tag, input int l, input logic ab);
        pattern = 8'h5A;
        len     = 4'(l);
        reps    = 4'd1;
        gap     = 4'd1;
        abort   = ab;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq($sformatf("%s cyc1", tag), outs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("%s cyc2", tag), outs(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pattern   = '0;
        len       = '0;
        reps      = '0;
        gap       = '0;
        bit_ready = 1'b1;
        #12;
        check_eq("reset outputs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("idle after reset", outs(), 32'd0);

        // Basic 4-bit, single repetition.
        run_job(8'b0000_1011, 4, 0, 0, 0);
        // Three repetitions with two-cycle gaps: 14 busy cycles.
        run_job(8'b0000_0110, 3, 2, 2, 0);
        // Backpressure: ready 1,0,0,1,0,0,...
        run_job(8'b0000_1001, 4, 0, 0, 1);
        // Abort on the 3rd bit, then an immediate fresh job.
        abort_at = 2;
        run_job(8'hA5, 8, 0, 0, 0);
        run_job(8'b0000_0010, 2, 1, 0, 0);
        // Ignored starts.
        idle_start("len0", 0, 1'b0);
        idle_start("len9", 9, 1'b0);
        idle_start("len15", 15, 1'b0);
        idle_start("abort_prio", 4, 1'b1);
        inject_at = 1;
        run_job(8'b0000_1011, 4, 1, 1, 0);
        inject_at = -2;
        run_job(8'b0000_0101, 3, 0, 0, 0);
        // Reset in the middle of a gap, then a normal job.
        reset_at = 4;
        run_job(8'b0000_0110, 3, 2, 3, 0);
        run_job(8'b0000_0001, 1, 2, 1, 0);
        // Maximum repetitions back to back, and full-width patterns.
        run_job(8'b0000_0010, 2, 15, 0, 0);
        run_job(8'b1100_1010, 8, 1, 15, 0);
        run_job(8'b0110_1001, 8, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
